cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Coprocessor 0 for the pipelined MIPS core.
- Sits at the M stage. Holds SR, Cause, EPC and PRId, and serves mfc0/mtc0.
- Arbitrates hardware interrupts against synchronous exceptions.
- Produces the IntExcReq request and the EPC value that the next-PC logic consumes on exception entry and on eret return.

Parameters:
- PRID, 32'h2020_1130, value returned when reading PRId (reg 15).
- IM_RESET, 6'b000000, reset value of SR.IM[15:10].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- A  input  5  CP0 register number for mfc0/mtc0.
- DIn  input  32  mtc0 write data.
- WE  input  1  mtc0 write enable.
- DOut  output  32  mfc0 read data; combinational from A.
- VPC  input  32  PC of the instruction currently in M.
- BD  input  1  M-stage instruction sits in a branch delay slot.
- ExcCodeIn  input  5  exception code of the M-stage instruction; 0 means none.
- HWInt  input  6  external interrupt lines, level sensitive.
- EXLClr  input  1  eret in M; clears SR.EXL.
- IntExcReq  output  1  take interrupt/exception this cycle.
- EPC  output  32  current EPC register value.

Behaviour:
- Reset (reset_n low, async):
  - SR = {16'b0, IM_RESET, 8'b0, EXL=0, IE=0}; Cause = 0; EPC = 0.
  - IntExcReq forced 0 while reset_n is low.
- Register map:
  - SR (12): bits [15:10] IM, [1] EXL, [0] IE; other bits read 0.
  - Cause (13): [31] BD, [15:10] IP, [6:2] ExcCode; other bits read 0.
  - EPC (14): 32-bit register.
  - PRId (15): reads PRID.
  - Any other A reads 0.
- Cause.IP <= HWInt every cycle, unconditionally; free-running sample.
- Request logic, combinational, same cycle:
  - IntReq = |(HWInt & SR.IM) & SR.IE & !SR.EXL.
  - ExcReq = (ExcCodeIn != 0) & !SR.EXL.
  - IntExcReq = IntReq | ExcReq.
- Handler state, encoded in EXL: NORMAL (EXL=0) and IN_HANDLER (EXL=1).
- NORMAL -> IN_HANDLER on a clock edge with IntExcReq=1:
  - SR.EXL <= 1.
  - Cause.BD <= BD.
  - Cause.ExcCode <= IntReq ? 5'd0 : ExcCodeIn. Interrupt has priority over exception.
  - EPC <= {(BD ? VPC-4 : VPC)[31:2], 2'b00}.
- IN_HANDLER -> NORMAL on a clock edge with EXLClr=1: SR.EXL <= 0.
- While EXL=1, all requests are masked, so nested interrupts/exceptions are impossible.
- mtc0 (WE=1):
  - Writes SR (only IM, EXL, IE bits stored) or EPC (full 32 bits).
  - Writes to Cause, PRId or any other register are ignored.
  - Write takes effect at the clock edge; a same-cycle mfc0 returns the old value (no internal bypass).
- Simultaneous events:
  - IntExcReq=1 with WE=1: the exception update wins and the mtc0 write is discarded, because that instruction is being cancelled.
  - EXLClr=1 with WE=1 to SR: EXLClr wins for the EXL bit; IM and IE take DIn.
  - EXLClr with IntExcReq cannot occur, since EXL=1 masks requests; if forced, the entry update wins.
- EPC output always reflects the register; the next-PC logic samples it on eret.
- Latency: request visible in the same cycle; state visible the next cycle.

Optional Feature:
- Macro CP0_BADVADDR_EN.
- When defined:
  - Adds input BadVAddrIn [31:0] and register BadVAddr (8), reset 0, read-only to mtc0.
  - BadVAddr <= BadVAddrIn on exception entry when ExcReq is taken (not an interrupt) and ExcCodeIn is 4 (AdEL) or 5 (AdES).
- When undefined: no port; reg 8 reads 0.

Test Plan:
- Reset, then mfc0 A=12/13/14/15 -> DOut = 0x0, 0x0, 0x0, 0x20201130; IntExcReq=0.
- mtc0 SR=0x0000_0401, then HWInt=6'b000001 with VPC=0x3008, BD=0:
  - IntExcReq=1 same cycle.
  - Next cycle: EPC=0x3008, SR.EXL=1, Cause.ExcCode=0, Cause.IP[10]=1.
- ExcCodeIn=10 (RI) with VPC=0x3104, BD=1, IE=0 -> IntExcReq=1; next cycle EPC=0x3100, Cause=0x8000_0028.
- Same-cycle HWInt[2] enabled and ExcCodeIn=12 -> ExcCode=0 (interrupt wins); a concurrent mtc0 EPC=0xDEAD_0000 is discarded.
- EXL=1 with ExcCodeIn=4 and HWInt enabled -> IntExcReq=0; EXLClr pulse -> EXL=0 next cycle, pending interrupt raises IntExcReq immediately.
- Assert reset_n low mid-handler (EXL=1, EPC=0x3008) -> all registers clear asynchronously without waiting for clk; IntExcReq=0.

Source files
------------

// File: rtl/cp0_unit.sv
// cp0_unit - Coprocessor 0 for the pipelined MIPS core, sitting at the M stage.
//
// Holds SR, Cause, EPC and PRId and serves mfc0/mtc0. Hardware interrupts
// are arbitrated against synchronous exceptions. On exception entry the block
// raises IntExcReq and latches EPC for the next-PC logic, which also reads
// EPC on eret.
//
// Optional feature: define CP0_BADVADDR_EN to add the BadVAddr register
// (reg 8, read-only) and the BadVAddrIn port. It captures the faulting
// address on AdEL/AdES entry. Without the macro, reg 8 reads 0.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset_n    in   1   asynchronous active-low reset
//   A          in   5   CP0 register number for mfc0/mtc0
//   DIn        in  32   mtc0 write data
//   WE         in   1   mtc0 write enable
//   DOut       out 32   mfc0 read data, combinational from A
//   VPC        in  32   PC of the M-stage instruction
//   BD         in   1   M-stage instruction is in a branch delay slot
//   ExcCodeIn  in   5   exception code of the M-stage instruction (0 = none)
//   HWInt      in   6   external interrupt lines, level sensitive
//   EXLClr     in   1   eret in M, clears SR.EXL
//   IntExcReq  out  1   take interrupt/exception this cycle
//   EPC        out 32   current EPC register
//   BadVAddrIn in  32   faulting address (only with CP0_BADVADDR_EN)
module cp0_unit #(
    parameter logic [31:0] PRID     = 32'h2020_1130,
    parameter logic [5:0]  IM_RESET = 6'b000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  A,
    input  logic [31:0] DIn,
    input  logic        WE,
    output logic [31:0] DOut,
    input  logic [31:0] VPC,
    input  logic        BD,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntExcReq,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0] BadVAddrIn,
`endif
    output logic [31:0] EPC
);

    // Handler state is exactly SR.EXL.
    typedef enum logic {NORMAL = 1'b0, IN_HANDLER = 1'b1} hstate_t;

    hstate_t     state, state_n;
    logic [5:0]  im, im_n;
    logic        ie, ie_n;
    logic        cause_bd, cause_bd_n;
    logic [5:0]  cause_ip;
    logic [4:0]  exc_code, exc_code_n;
    logic [31:0] epc_q, epc_n;
    logic [31:0] epc_entry;
    logic        exl, int_req, exc_req, req;

    assign exl     = (state == IN_HANDLER);
    assign int_req = (|(HWInt & im)) & ie & ~exl;
    assign exc_req = (ExcCodeIn != 5'd0) & ~exl;
    // Gated with reset_n so nothing is requested while reset is held.
    assign req       = (int_req | exc_req) & reset_n;
    assign IntExcReq = req;
    assign EPC       = epc_q;

    // A delay-slot instruction restarts at its branch.
    assign epc_entry = BD ? (VPC - 32'd4) : VPC;

    // Next-state and register updates. Entry wins over any mtc0 because the
    // writing instruction is being cancelled. eret wins over an SR write for EXL.
    always_comb begin
        state_n    = state;
        im_n       = im;
        ie_n       = ie;
        cause_bd_n = cause_bd;
        exc_code_n = exc_code;
        epc_n      = epc_q;
        if (req) begin
            state_n    = IN_HANDLER;
            cause_bd_n = BD;
            exc_code_n = int_req ? 5'd0 : ExcCodeIn;
            epc_n      = {epc_entry[31:2], 2'b00};
        end else begin
            if (WE && A == 5'd12) begin
                im_n    = DIn[15:10];
                ie_n    = DIn[0];
                state_n = DIn[1] ? IN_HANDLER : NORMAL;
            end
            if (EXLClr)
                state_n = NORMAL;
            if (WE && A == 5'd14)
                epc_n = DIn;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= NORMAL;
            im       <= IM_RESET;
            ie       <= 1'b0;
            cause_bd <= 1'b0;
            cause_ip <= 6'd0;
            exc_code <= 5'd0;
            epc_q    <= 32'd0;
        end else begin
            state    <= state_n;
            im       <= im_n;
            ie       <= ie_n;
            cause_bd <= cause_bd_n;
            cause_ip <= HWInt;       // free-running sample of the lines
            exc_code <= exc_code_n;
            epc_q    <= epc_n;
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr;

    // Captured only for address-error exceptions, never for interrupts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            badvaddr <= 32'd0;
        else if (req && !int_req && (ExcCodeIn == 5'd4 || ExcCodeIn == 5'd5))
            badvaddr <= BadVAddrIn;
    end
`endif

    // mfc0 read mux; no bypass, so a same-cycle mtc0 is not visible.
    always_comb begin
        DOut = 32'd0;
        case (A)
`ifdef CP0_BADVADDR_EN
            5'd8:  DOut = badvaddr;
`endif
            5'd12: DOut = {16'd0, im, 8'd0, exl, ie};
            5'd13: DOut = {cause_bd, 15'd0, cause_ip, 3'd0, exc_code, 2'd0};
            5'd14: DOut = epc_q;
            5'd15: DOut = PRID;
            default: DOut = 32'd0;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{DIn[31:16], DIn[9:2], epc_entry[1:0]};

endmodule

// File: tb/tb_cp0_unit.sv
module tb_cp0_unit;
    localparam logic [31:0] PRID = 32'h2020_1130;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  A;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] DOut;
    logic [31:0] VPC;
    logic        BD;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntExcReq;
    logic [31:0] EPC;
`ifdef CP0_BADVADDR_EN
    logic [31:0] BadVAddrIn = 32'd0;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model: architectural register words.
    logic [31:0] m_sr, m_cause, m_epc;

    cp0_unit dut (
        .clk(clk), .reset_n(reset_n), .A(A), .DIn(DIn), .WE(WE), .DOut(DOut),
        .VPC(VPC), .BD(BD), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
        .EXLClr(EXLClr), .IntExcReq(IntExcReq),
`ifdef CP0_BADVADDR_EN
        .BadVAddrIn(BadVAddrIn),
`endif
        .EPC(EPC)
    );

    always #5 clk = ~clk;

    function automatic logic m_int();
        return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_exc();
        return (ExcCodeIn != 5'd0) && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return reset_n && (m_int() || m_exc());
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
    endtask

    // Advance the model by one clock using the current inputs, then the DUT.
    task automatic tick();
        logic ir, er;
        logic [31:0] pc;
        ir = m_int();
        er = m_exc();
        if (!reset_n) begin
            m_reset();
        end else if (ir || er) begin
            pc      = BD ? VPC - 32'd4 : VPC;
            m_sr    = m_sr | 32'h2;
            m_epc   = pc & ~32'd3;
            m_cause = {BD, 15'd0, HWInt, 3'd0, (ir ? 5'd0 : ExcCodeIn), 2'd0};
        end else begin
            m_cause = (m_cause & 32'h8000_007C) | ({26'd0, HWInt} << 10);
            if (WE && A == 5'd12) m_sr = DIn & 32'h0000_FC03;
            if (EXLClr) m_sr = m_sr & ~32'h2;
            if (WE && A == 5'd14) m_epc = DIn;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        A = 5'd0; DIn = 32'd0; WE = 1'b0; VPC = 32'd0; BD = 1'b0;
        ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_rd [4];
        exp_rd = '{32'h0, 32'h0, 32'h0, PRID};
        idle_inputs();
        reset_n = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            A = 5'(12 + i);
            #1;
            n_vec++;
            if (DOut !== exp_rd[i]) begin
                n_err++;
                $display("FAIL reset_read A=%0d got=%h exp=%h", A, DOut, exp_rd[i]);
            end
        end
        n_vec++;
        if (IntExcReq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_req got=%b exp=0", IntExcReq);
        end
    endtask

    task automatic test_interrupt();
        A = 5'd12; DIn = 32'h0000_0401; WE = 1'b1;
        tick();
        WE = 1'b0;
        n_vec++;
        if (DOut !== 32'h0000_0401) begin
            n_err++;
            $display("FAIL int_sr_write got=%h exp=%h", DOut, 32'h0000_0401);
        end
        HWInt = 6'b000001; VPC = 32'h3008; BD = 1'b0;
        #1;
        n_vec++;
        if (IntExcReq !== 1'b1) begin
            n_err++;
            $display("FAIL int_req got=%b exp=1", IntExcReq);
        end
        tick();
        n_vec++;
        if (EPC !== 32'h3008) begin
            n_err++;
            $display("FAIL int_epc got=%h exp=%h", EPC, 32'h3008);
        end
        A = 5'd12; #1;
        n_vec++;
        if (DOut !== 32'h0000_0403) begin
            n_err++;
            $display("FAIL int_sr_exl got=%h exp=%h", DOut, 32'h0000_0403);
        end
        A = 5'd13; #1;
        n_vec++;
        if (DOut !== 32'h0000_0400) begin
            n_err++;
            $display("FAIL int_cause got=%h exp=%h", DOut, 32'h0000_0400);
        end
        n_vec++;
        if (IntExcReq !== 1'b0) begin
            n_err++;
            $display("FAIL int_masked got=%b exp=0", IntExcReq);
        end
        HWInt = 6'd0; EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
    endtask

    task automatic test_exception();
        A = 5'd12; DIn = 32'h0; WE = 1'b1;
        tick();
        WE = 1'b0;
        ExcCodeIn = 5'd10; VPC = 32'h3104; BD = 1'b1; HWInt = 6'd0;
        #1;
        n_vec++;
        if (IntExcReq !== 1'b1) begin
            n_err++;
            $display("FAIL exc_req got=%b exp=1", IntExcReq);
        end
        tick();
        ExcCodeIn = 5'd0; BD = 1'b0;
        n_vec++;
        if (EPC !== 32'h3100) begin
            n_err++;
            $display("FAIL exc_epc got=%h exp=%h", EPC, 32'h3100);
        end
        A = 5'd13; #1;
        n_vec++;
        if (DOut !== 32'h8000_0028) begin
            n_err++;
            $display("FAIL exc_cause got=%h exp=%h", DOut, 32'h8000_0028);
        end
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
    endtask

    task automatic test_priority();
        A = 5'd12; DIn = 32'h0000_1001; WE = 1'b1;
        tick();
        HWInt = 6'b000100; ExcCodeIn = 5'd12; VPC = 32'h4000; BD = 1'b0;
        A = 5'd14; DIn = 32'hDEAD_0000; WE = 1'b1;
        #1;
        n_vec++;
        if (IntExcReq !== 1'b1) begin
            n_err++;
            $display("FAIL prio_req got=%b exp=1", IntExcReq);
        end
        tick();
        WE = 1'b0; ExcCodeIn = 5'd0;
        n_vec++;
        if (EPC !== 32'h4000) begin
            n_err++;
            $display("FAIL prio_epc_discard got=%h exp=%h", EPC, 32'h4000);
        end
        A = 5'd13; #1;
        n_vec++;
        if (DOut !== 32'h0000_1000) begin
            n_err++;
            $display("FAIL prio_cause got=%h exp=%h", DOut, 32'h0000_1000);
        end
    endtask

    // Entered with EXL=1 and HWInt[2] still asserted and enabled.
    task automatic test_masking();
        ExcCodeIn = 5'd4;
        #1;
        n_vec++;
        if (IntExcReq !== 1'b0) begin
            n_err++;
            $display("FAIL mask_req got=%b exp=0", IntExcReq);
        end
        ExcCodeIn = 5'd0; EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        A = 5'd12; #1;
        n_vec++;
        if (DOut !== 32'h0000_1001) begin
            n_err++;
            $display("FAIL mask_eret_sr got=%h exp=%h", DOut, 32'h0000_1001);
        end
        n_vec++;
        if (IntExcReq !== 1'b1) begin
            n_err++;
            $display("FAIL mask_pending_req got=%b exp=1", IntExcReq);
        end
        VPC = 32'h3008;
        tick();
        HWInt = 6'd0;
    endtask

    // Entered mid-handler with EXL=1, EPC=0x3008.
    task automatic test_async_reset();
        #1;
        reset_n = 1'b0;
        ExcCodeIn = 5'd5;
        m_reset();
        A = 5'd12; #1;
        n_vec++;
        if (DOut !== 32'h0) begin
            n_err++;
            $display("FAIL areset_sr got=%h exp=0", DOut);
        end
        n_vec++;
        if (EPC !== 32'h0) begin
            n_err++;
            $display("FAIL areset_epc got=%h exp=0", EPC);
        end
        A = 5'd13; #1;
        n_vec++;
        if (DOut !== 32'h0) begin
            n_err++;
            $display("FAIL areset_cause got=%h exp=0", DOut);
        end
        n_vec++;
        if (IntExcReq !== 1'b0) begin
            n_err++;
            $display("FAIL areset_req got=%b exp=0", IntExcReq);
        end
        ExcCodeIn = 5'd0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        logic [4:0] regs [6];
        regs = '{5'd8, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
        for (int i = 0; i < 400; i++) begin
            A         = regs[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) A = 5'($urandom);
            DIn       = $urandom;
            WE        = ($urandom_range(0, 9) < 3);
            VPC       = $urandom;
            BD        = 1'($urandom);
            ExcCodeIn = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            HWInt     = 6'($urandom);
            EXLClr    = ($urandom_range(0, 3) == 0);
            #1;
            n_vec++;
            if (IntExcReq !== m_req()) begin
                n_err++;
                $display("FAIL rand_req i=%0d got=%b exp=%b", i, IntExcReq, m_req());
            end
            n_vec++;
            if (DOut !== m_read(A)) begin
                n_err++;
                $display("FAIL rand_dout i=%0d A=%0d got=%h exp=%h", i, A, DOut, m_read(A));
            end
            n_vec++;
            if (EPC !== m_epc) begin
                n_err++;
                $display("FAIL rand_epc i=%0d got=%h exp=%h", i, EPC, m_epc);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_exception();
        test_priority();
        test_masking();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
